// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, datapath
// select encodings and the FSM state type.
// Imported by multicycle_controller and mc_wait_timer.
package multicycle_controller_pkg;

   // Opcode field values (Instruction[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALUOp encodings
   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   // ALUSrcB encodings
   localparam logic [1:0] SRCB_REGB    = 2'b00;
   localparam logic [1:0] SRCB_FOUR    = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

   // PCSource encodings
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_R_EXEC    = 4'd6,
      S_R_WB      = 4'd7,
      S_ADDI_EXEC = 4'd8,
      S_ADDI_WB   = 4'd9,
      S_BRANCH    = 4'd10,
      S_JUMP      = 4'd11
   } state_t;

   // States that issue a memory access and may wait on MemReady
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEM_READ) || (s == S_MEM_WRITE);
   endfunction

   function automatic logic is_legal_op(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
   endfunction

endpackage

// File: rtl/multicycle_controller_wait_timer.sv
// mc_wait_timer: counts consecutive not-ready cycles in a memory state and
// flags a timeout once WAIT_LIMIT wait cycles have elapsed (0 = never).
// Ports: Clk, Rst (sync, active-high), active (in memory state), ready
// (MemReady), timeout (combinational, only while active and not ready).
import multicycle_controller_pkg::*;

module mc_wait_timer #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic Clk,
   input  logic Rst,
   input  logic active,
   input  logic ready,
   output logic timeout
);

   localparam int CW = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
   localparam logic [CW-1:0] LIMIT_C = CW'(WAIT_LIMIT);

   logic [CW-1:0] count;

   // Ready on the limit cycle wins: timeout requires ready low.
   always_comb begin
      timeout = (WAIT_LIMIT != 0) && active && !ready && (count == LIMIT_C);
   end

   // Every way out of a memory state (ready, timeout, or not being in one)
   // clears the count; a timeout in FETCH stays in FETCH, so it clears too.
   always_ff @(posedge Clk) begin
      if (Rst || !active || ready || timeout || (WAIT_LIMIT == 0))
         count <= '0;
      else
         count <= count + CW'(1);
   end

endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: FSM sequencing the multicycle MIPS datapath
// (fetch/decode/execute/memory/writeback), with memory-wait timeout.
// Ports: Clk, Rst (sync active-high), Instruction, MemReady, Zero in;
// all datapath selects/enables plus InstrDone, IllegalOp, MemFault out.
// Optional MC_PERF_CNT_EN adds CycleCount and InstrCount outputs.
import multicycle_controller_pkg::*;

module multicycle_controller #(
   parameter int WAIT_LIMIT = 15,
   parameter int CNT_W      = 32
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [31:0] Instruction,
   input  logic        MemReady,
   input  logic        Zero,
   output logic        PCWrite,
   output logic        PCWriteCond,
   output logic        IorD,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic        MemtoReg,
   output logic        RegDst,
   output logic        RegWrite,
   output logic        ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [1:0]  ALUOp,
   output logic [1:0]  PCSource,
   output logic        InstrDone,
   output logic        IllegalOp,
   output logic        MemFault
`ifdef MC_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0] CycleCount,
   output logic [CNT_W-1:0] InstrCount
`endif
);

   state_t     state;
   logic       is_sw;     // lw/sw choice captured in DECODE
   logic       timeout;
   logic [5:0] opcode;

   assign opcode = Instruction[31:26];

   // Branch outcome is resolved by the datapath (PCWriteCond & Zero), and
   // only the opcode field matters here.
   logic unused_inputs;
   assign unused_inputs = ^{Zero, Instruction[25:0]};

   mc_wait_timer #(.WAIT_LIMIT(WAIT_LIMIT)) u_wait_timer (
      .Clk     (Clk),
      .Rst     (Rst),
      .active  (is_mem_state(state)),
      .ready   (MemReady),
      .timeout (timeout)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state <= S_FETCH;
         is_sw <= 1'b0;
      end else begin
         case (state)
            S_FETCH: begin
               if (MemReady) state <= S_DECODE;
               else          state <= S_FETCH;   // wait, or retry after timeout
            end
            S_DECODE: begin
               is_sw <= (opcode == OP_SW);
               case (opcode)
                  OP_RTYPE:     state <= S_R_EXEC;
                  OP_LW, OP_SW: state <= S_MEM_ADDR;
                  OP_BEQ:       state <= S_BRANCH;
                  OP_J:         state <= S_JUMP;
                  OP_ADDI:      state <= S_ADDI_EXEC;
                  default:      state <= S_FETCH;
               endcase
            end
            S_MEM_ADDR:  state <= is_sw ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
               if (MemReady)     state <= S_MEM_WB;
               else if (timeout) state <= S_FETCH;
            end
            S_MEM_WRITE: begin
               if (MemReady || timeout) state <= S_FETCH;
            end
            S_R_EXEC:    state <= S_R_WB;
            S_ADDI_EXEC: state <= S_ADDI_WB;
            default:     state <= S_FETCH;   // all writeback/branch/jump states
         endcase
      end
   end

   always_comb begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegDst      = 1'b0;
      RegWrite    = 1'b0;
      ALUSrcA     = 1'b0;
      ALUSrcB     = SRCB_REGB;
      ALUOp       = ALUOP_ADD;
      PCSource    = PCSRC_ALU;
      InstrDone   = 1'b0;
      IllegalOp   = 1'b0;
      MemFault    = 1'b0;
      if (!Rst) begin
         MemFault = timeout;
         case (state)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = SRCB_FOUR;
               IRWrite = MemReady;
               PCWrite = MemReady;
            end
            S_DECODE: begin
               ALUSrcB   = SRCB_IMM_SH2;
               IllegalOp = !is_legal_op(opcode);
               InstrDone = !is_legal_op(opcode);
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
               ALUSrcA = 1'b1;
               ALUSrcB = SRCB_IMM;
            end
            S_MEM_READ: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WB: begin
               RegWrite  = 1'b1;
               MemtoReg  = 1'b1;
               InstrDone = 1'b1;
            end
            S_MEM_WRITE: begin
               // Write strobe is withdrawn on the timeout cycle.
               MemWrite  = !timeout;
               IorD      = 1'b1;
               InstrDone = MemReady;
            end
            S_R_EXEC: begin
               ALUSrcA = 1'b1;
               ALUOp   = ALUOP_FUNCT;
            end
            S_R_WB: begin
               RegWrite  = 1'b1;
               RegDst    = 1'b1;
               InstrDone = 1'b1;
            end
            S_ADDI_WB: begin
               RegWrite  = 1'b1;
               InstrDone = 1'b1;
            end
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = ALUOP_SUB;
               PCWriteCond = 1'b1;
               PCSource    = PCSRC_ALUOUT;
               InstrDone   = 1'b1;
            end
            S_JUMP: begin
               PCWrite   = 1'b1;
               PCSource  = PCSRC_JUMP;
               InstrDone = 1'b1;
            end
            default: ;
         endcase
      end
   end

`ifdef MC_PERF_CNT_EN
   always_ff @(posedge Clk) begin
      if (Rst) begin
         CycleCount <= '0;
         InstrCount <= '0;
      end else begin
         CycleCount <= CycleCount + CNT_W'(1);
         if (InstrDone) InstrCount <= InstrCount + CNT_W'(1);
      end
   end
`else
   localparam int unused_cnt_w = CNT_W;
`endif

endmodule
